// File: rtl/riscv_m_pkg.sv
// Shared RV32M definitions: funct3 encodings, multiply/divide FSM state type, XLEN.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: XLEN, F3_MUL..F3_REMU, state_t {IDLE, CALC, FIX, DONE}, operand signedness helpers.
package riscv_m_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // MUL is treated as unsigned: the low product word is the same either way.
  function automatic logic isSignedA(input logic [2:0] f);
    return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
  endfunction

  function automatic logic isSignedB(input logic [2:0] f);
    return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Sign correction and result selection for the iterative multiply/divide unit.
// Latency: combinational.
// Backpressure: none; consumed in the FIX state of mul_div_unit.
// Ports: iFunct3 op, iRaw {remainder,quotient} or 64-bit product of magnitudes,
//        iSignA/iSignB latched operand signs, iDivZero/iOverflow special cases, oResult.
// Config: MULDIV_DIV_EN enables the divide/remainder results; otherwise those ops return 0.
module muldiv_signfix
  import riscv_m_pkg::*;
(
  input  logic [2:0]        iFunct3,
  input  logic [2*XLEN-1:0] iRaw,
  input  logic              iSignA,
  input  logic              iSignB,
  input  logic              iDivZero,
  input  logic              iOverflow,
  output logic [XLEN-1:0]   oResult
);

  logic [2*XLEN-1:0] prodFixed;

`ifdef MULDIV_DIV_EN
  logic [XLEN-1:0] quoFixed;
  logic [XLEN-1:0] remFixed;
`else
  logic unusedDivFlags;
  assign unusedDivFlags = iDivZero ^ iOverflow;
`endif

  always_comb begin
    prodFixed = (iSignA ^ iSignB) ? -iRaw : iRaw;
    oResult   = '0;
`ifdef MULDIV_DIV_EN
    // Quotient lives in the low word, remainder in the high word.
    quoFixed  = (iSignA ^ iSignB) ? -iRaw[XLEN-1:0] : iRaw[XLEN-1:0];
    remFixed  = iSignA ? -iRaw[2*XLEN-1:XLEN] : iRaw[2*XLEN-1:XLEN];
`endif
    case (iFunct3)
      F3_MUL:                        oResult = prodFixed[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  oResult = prodFixed[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
      F3_DIV, F3_DIVU: begin
        if (iDivZero)       oResult = '1;
        else if (iOverflow) oResult = {1'b1, {(XLEN-1){1'b0}}};
        else                oResult = quoFixed;
      end
      // Divide by zero leaves |A| in the remainder, and the dividend-sign
      // correction turns it back into A, so only overflow needs forcing.
      F3_REM, F3_REMU: begin
        if (iOverflow) oResult = '0;
        else           oResult = remFixed;
      end
`endif
      default: oResult = '0;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide.
// Latency: fixed 34 cycles start-to-done (32 iterations + FIX + DONE); throughput 1 op / 34 cycles.
// Backpressure: none; iStart is only accepted in IDLE or DONE and ignored while oBusy.
// Ports: iCLK, iRST (async, active-high), iStart, iFunct3, iOperandA, iOperandB,
//        oResult (held until next accepted start), oBusy, oDone (1-cycle pulse).
// Config: define MULDIV_DIV_EN for the divide/remainder datapath; without it, div ops return 0.
module mul_div_unit
  import riscv_m_pkg::*;
(
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iStart,
  input  logic [2:0]        iFunct3,
  input  logic [XLEN-1:0]   iOperandA,
  input  logic [XLEN-1:0]   iOperandB,
  output logic [XLEN-1:0]   oResult,
  output logic              oBusy,
  output logic              oDone
);

  state_t            state, nextState;
  logic [4:0]        count;
  logic [2*XLEN-1:0] acc;        // product, or {remainder, quotient}
  logic [XLEN-1:0]   opReg;      // |A| multiplicand, or |B| divisor
  logic [2:0]        opFunct3;
  logic              signA, signB;
  logic              divZero, overflow;
  logic              accept;
  logic              aSigned, bSigned;
  logic [XLEN-1:0]   absA, absB;
  logic [XLEN:0]     mulSum;
  logic [2*XLEN-1:0] mulNext;
  logic [XLEN-1:0]   fixResult;

  assign accept  = iStart && ((state == IDLE) || (state == DONE));
  assign aSigned = isSignedA(iFunct3);
  assign bSigned = isSignedB(iFunct3);
  assign absA    = (aSigned && iOperandA[XLEN-1]) ? -iOperandA : iOperandA;
  assign absB    = (bSigned && iOperandB[XLEN-1]) ? -iOperandB : iOperandB;

  // Multiplier sits in the low word and is consumed LSB first while partial
  // sums shift in from the top.
  assign mulSum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opReg : '0)};
  assign mulNext = {mulSum, acc[XLEN-1:1]};

`ifdef MULDIV_DIV_EN
  logic [XLEN:0]     divShift, divDiff;
  logic [2*XLEN-1:0] divNext;
  logic              divZeroIn, overflowIn;

  // A set borrow bit means the trial subtract failed: keep the shifted remainder.
  assign divShift   = acc[2*XLEN-1:XLEN-1];
  assign divDiff    = divShift - {1'b0, opReg};
  assign divNext    = divDiff[XLEN] ? {divShift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                    : {divDiff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
  assign divZeroIn  = (iOperandB == '0);
  assign overflowIn = ((iFunct3 == F3_DIV) || (iFunct3 == F3_REM)) &&
                      (iOperandA == {1'b1, {(XLEN-1){1'b0}}}) && (iOperandB == '1);
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    oBusy     = 1'b0;
    oDone     = 1'b0;
    case (state)
      IDLE: if (iStart) nextState = CALC;
      CALC: begin
        oBusy = 1'b1;
        if (count == 5'd0) nextState = FIX;
      end
      FIX: begin
        oBusy     = 1'b1;
        nextState = DONE;
      end
      DONE: begin
        oDone     = 1'b1;
        nextState = iStart ? CALC : IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      count    <= '0;
      acc      <= '0;
      opReg    <= '0;
      opFunct3 <= '0;
      signA    <= 1'b0;
      signB    <= 1'b0;
      divZero  <= 1'b0;
      overflow <= 1'b0;
      oResult  <= '0;
    end else if (accept) begin
      count    <= 5'd31;
      opFunct3 <= iFunct3;
      signA    <= aSigned & iOperandA[XLEN-1];
      signB    <= bSigned & iOperandB[XLEN-1];
      acc      <= {{XLEN{1'b0}}, (iFunct3[2] ? absA : absB)};
      opReg    <= iFunct3[2] ? absB : absA;
`ifdef MULDIV_DIV_EN
      divZero  <= divZeroIn;
      overflow <= overflowIn;
`endif
    end else if (state == CALC) begin
`ifdef MULDIV_DIV_EN
      acc <= opFunct3[2] ? divNext : mulNext;
`else
      acc <= mulNext;
`endif
      if (count != 5'd0) count <= count - 5'd1;
    end else if (state == FIX) begin
      oResult <= fixResult;
    end
  end

  muldiv_signfix uSignFix (
    .iFunct3   (opFunct3),
    .iRaw      (acc),
    .iSignA    (signA),
    .iSignB    (signB),
    .iDivZero  (divZero),
    .iOverflow (overflow),
    .oResult   (fixResult)
  );

endmodule
